// File: rtl/video_mem_ctrl.sv
// ---------------------------------------------------------------------------
// video_mem_ctrl
//
// Sequences the single shared port of a banked video RAM between the raster
// display (reads) and the frame loader (write stream). The loader fills a
// back bank while the front bank is displayed. At a frame boundary a
// completed back bank becomes the displayed bank, and the next bank in
// rotation becomes the new back bank.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   frame_start  one-cycle pulse at the start of each displayed frame
//   disp_req     display needs a pixel read this cycle (strict priority)
//   disp_x/y     display read position, passed through unmodified
//   wr_valid     loader has a pixel
//   wr_data      loader pixel value
//   wr_ready     loader pixel accepted when wr_valid && wr_ready
//   mem_bank     RAM bank select (registered)
//   mem_x/y      RAM position (registered)
//   mem_data     RAM write data (registered)
//   mem_we       RAM write enable (registered)
//   disp_bank    bank currently being displayed
//   frame_ready  back bank complete and waiting for a swap
//   underrun     one-cycle pulse: frame_start came before the back bank was done
// ---------------------------------------------------------------------------
module video_mem_ctrl #(
  parameter int WIDTH     = 10,
  parameter int HEIGHT    = 20,
  parameter int NUM_BANKS = 16,
  parameter int X_ADDRW   = $clog2(WIDTH),
  parameter int Y_ADDRW   = $clog2(HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               disp_req,
  input  logic [X_ADDRW-1:0] disp_x,
  input  logic [Y_ADDRW-1:0] disp_y,
  input  logic               wr_valid,
  input  logic               wr_data,
  output logic               wr_ready,
  output logic [3:0]         mem_bank,
  output logic [X_ADDRW-1:0] mem_x,
  output logic [Y_ADDRW-1:0] mem_y,
  output logic               mem_data,
  output logic               mem_we,
  output logic [3:0]         disp_bank,
  output logic               frame_ready,
  output logic               underrun
);

  typedef enum logic {
    FILL = 1'b0,  // loader writing the back bank
    FULL = 1'b1   // back bank complete, writes blocked until the swap
  } state_t;

  localparam logic [X_ADDRW-1:0] X_LAST    = X_ADDRW'(WIDTH - 1);
  localparam logic [Y_ADDRW-1:0] Y_LAST    = Y_ADDRW'(HEIGHT - 1);
  localparam logic [3:0]         BANK_MASK = 4'(NUM_BANKS - 1);

  state_t               state;
  state_t               state_next;
  logic [3:0]           wr_bank;
  logic [X_ADDRW-1:0]   wx;
  logic [Y_ADDRW-1:0]   wy;
  logic                 accept;
  logic                 last_pixel;
  logic                 swap;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: asynchronous reset is in the sensitivity list so the outputs clear
  // the moment rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (accept && last_pixel) state_next = FULL;
      FULL:    if (frame_start)          state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // Combinational outputs and grant decode
  // -------------------------------------------------------------------------
  always_comb begin
    // Display always wins; the loader is held off while reset is asserted.
    wr_ready   = (state == FILL) && !disp_req && !rst;
    accept     = wr_valid && wr_ready;
    last_pixel = (wx == X_LAST) && (wy == Y_LAST);
    // A swap only happens on a completed frame; frame_start during FILL is
    // an underrun and leaves the banks alone.
    swap       = frame_start && (state == FULL);
  end

  // -------------------------------------------------------------------------
  // Datapath: banks, write raster, registered memory port, status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bank   <= 4'd0;
      wr_bank     <= 4'd1;
      wx          <= '0;
      wy          <= '0;
      mem_bank    <= 4'd0;
      mem_x       <= '0;
      mem_y       <= '0;
      mem_data    <= 1'b0;
      mem_we      <= 1'b0;
      frame_ready <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun    <= frame_start && (state == FILL);
      // Registered from the next state so it tracks FULL with no extra lag.
      frame_ready <= (state_next == FULL);

      if (swap) begin
        disp_bank <= wr_bank;
        wr_bank   <= (wr_bank + 4'd1) & BANK_MASK;
      end

      // Row-major raster; the counters return to the origin after the last
      // pixel so the next frame needs no further clearing.
      if (accept) begin
        if (last_pixel) begin
          wx <= '0;
          wy <= '0;
        end else if (wx == X_LAST) begin
          wx <= '0;
          wy <= wy + Y_ADDRW'(1);
        end else begin
          wx <= wx + X_ADDRW'(1);
        end
      end

      if (disp_req) begin
        mem_bank <= disp_bank;
        mem_x    <= disp_x;
        mem_y    <= disp_y;
        mem_data <= 1'b0;
        mem_we   <= 1'b0;
      end else if (accept) begin
        mem_bank <= wr_bank;
        mem_x    <= wx;
        mem_y    <= wy;
        mem_data <= wr_data;
        mem_we   <= 1'b1;
      end else begin
        // Idle: address lines hold, strobes drop.
        mem_data <= 1'b0;
        mem_we   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/video_mem_ctrl.md
Name: video_mem_ctrl

Overview:
- Sequences the single shared port of the banked video RAM between two requesters: the raster display (read) and the frame loader (write stream).
- Fills a back bank from the loader while the front bank is displayed, then rotates banks at frame boundaries, giving tear-free multi-buffering.
- Drives the memory's bank select, x/y position, data and write-enable.

Parameters:
- WIDTH, 10, frame width in pixels
- HEIGHT, 20, frame height in pixels
- NUM_BANKS, 16, number of RAM banks; bank select wraps modulo NUM_BANKS (power of two, ≤16)
- X_ADDRW, $clog2(WIDTH), x coordinate width
- Y_ADDRW, $clog2(HEIGHT), y coordinate width

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of each displayed frame (from VGA timing)
- disp_req  in  1  display needs a pixel read this cycle
- disp_x  in  X_ADDRW  display read x
- disp_y  in  Y_ADDRW  display read y
- wr_valid  in  1  loader has a pixel
- wr_data  in  1  loader pixel value
- wr_ready  out  1  pixel accepted when wr_valid && wr_ready
- mem_bank  out  4  bank select to RAM
- mem_x  out  X_ADDRW  RAM x position
- mem_y  out  Y_ADDRW  RAM y position
- mem_data  out  1  RAM write data
- mem_we  out  1  RAM write enable
- disp_bank  out  4  bank currently displayed
- frame_ready  out  1  back bank complete, awaiting swap
- underrun  out  1  one-cycle pulse: frame_start arrived before back bank was complete

Behaviour:
- State machine has two states:
  - FILL: loader writing the back bank.
  - FULL: back bank complete; writes are blocked.
- Reset values (async assert):
  - state = FILL; disp_bank = 0; wr_bank = 1.
  - Write counters wx = wy = 0.
  - mem_bank = mem_x = mem_y = mem_data = mem_we = 0.
  - frame_ready = underrun = 0.
  - Reset mid-fill discards the partial frame.
- Arbitration: display has strict priority.
  - wr_ready = (state == FILL) && !disp_req. This is combinational from registered state and the disp_req input.
  - No write is accepted while rst is high.
- Memory outputs are registered, with 1-cycle latency from the grant:
  - If disp_req: mem_bank = disp_bank, mem_x = disp_x, mem_y = disp_y, mem_we = 0, mem_data = 0.
  - Else if write accepted: mem_bank = wr_bank, mem_x = wx, mem_y = wy, mem_data = wr_data, mem_we = 1.
  - Else (idle): mem_we = 0, mem_data = 0; bank/x/y hold their previous values.
- Write raster: each accepted pixel increments wx.
  - At wx == WIDTH-1: wx wraps to 0 and wy increments.
  - At wx == WIDTH-1 && wy == HEIGHT-1: wx and wy clear to 0, and state goes to FULL.
  - Pixels are written row-major, exactly WIDTH*HEIGHT per frame.
- frame_ready = (state == FULL), registered.
- On frame_start, decisions use the pre-edge state:
  - FULL: disp_bank <= wr_bank; wr_bank <= (wr_bank+1) mod NUM_BANKS; state goes to FILL. Write counters are already 0.
  - FILL: underrun pulses high for the next cycle. Banks are unchanged, the display repeats the current frame, and filling continues from the current wx/wy.
- Simultaneous frame_start and final pixel accept (state FILL before the edge):
  - underrun pulses and the state goes to FULL.
  - The swap occurs at the next frame_start.
- wr_bank never equals disp_bank. Both are 4 bits; values ≥ NUM_BANKS are never produced.
- Display reads are never stalled or reordered. disp_x/disp_y are passed through unmodified; no range checking.

Test Plan:
1. Reset check: assert rst mid-stream → all outputs 0 immediately (async), disp_bank = 0, wr_ready = 1 after deassert when disp_req = 0.
2. Full fill and swap: stream 200 pixels (alternating 1/0) with disp_req = 0 → cycle after each accept mem_we = 1, mem_bank = 1, mem_x/mem_y step (0,0)…(9,19); frame_ready = 1 and wr_ready = 0 after the 200th; frame_start → disp_bank = 1, next fill targets bank 2, frame_ready = 0.
3. Contention: disp_req = 1, disp_x = 3, disp_y = 7, wr_valid = 1 → wr_ready = 0; next cycle mem_we = 0, mem_bank = disp_bank, mem_x = 3, mem_y = 7; the loader pixel is accepted the first cycle disp_req = 0, with no loss or duplication (count = 200 exactly).
4. Underrun: frame_start after 150 pixels → underrun = 1 for one cycle, disp_bank unchanged; next write lands at (0,15); after 200 pixels plus frame_start, swap occurs.
5. Same-edge corner: 200th accept coincident with frame_start → underrun pulses, frame_ready = 1, no swap; next frame_start swaps.
6. Bank wrap: 16 consecutive full frames with swaps → disp_bank sequence 1..15, 0; wr_bank after disp_bank = 15 is 0, then 1; never equal to disp_bank.
